// File: rtl/jtframe_dwnld_conv.sv
// Download serialiser: queues DIN_W-bit ioctl words and replays them as byte writes to
// the ROM sink (with spacing and back-pressure), the DIP-switch bytes or core_mod.
module jtframe_dwnld_conv #(
  parameter int         DIN_W    = 16,
  parameter int         DEPTH    = 4,
  parameter int         GAP      = 24,
  parameter int         DIPBYTES = 4,
  parameter logic [7:0] ROM_IDX  = 8'd0,
  parameter logic [7:0] MOD_IDX  = 8'd1,
  parameter logic [7:0] DIP_IDX  = 8'd254
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  ioctl_download,
  input  logic                  dwnld_wr,
  input  logic [26:0]           dwnld_addr,
  input  logic [DIN_W-1:0]      dwnld_data,
  input  logic [7:0]            dwnld_index,
  input  logic                  rom_ok,
  output logic                  rom_wr,
  output logic [24:0]           rom_addr,
  output logic [7:0]            rom_data,
  output logic [8*DIPBYTES-1:0] dipsw,
  output logic [6:0]            core_mod,
  output logic                  busy,
  output logic                  overflow
);
  localparam int NB = DIN_W / 8;
  localparam int B  = $clog2(NB);
  localparam int LW = (B > 0) ? B : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int EW = 25 + DIN_W + 8;
  localparam logic [LW-1:0] LAST  = LW'(NB - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [24:0]   AMASK = 25'(NB - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, WAIT} state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           cnt_q;
  logic                  ovf_q, dl_q;
  logic                  full, push, pop, lane_done;
  logic [24:0]           waddr_q, waddr_d;
  logic [DIN_W-1:0]      wdata_q, wdata_d;
  logic [7:0]            widx_q, widx_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [6:0]            core_mod_q, core_mod_d;
  logic [8*DIPBYTES-1:0] dipsw_q, dipsw_d;
  logic [7:0]            byte_w;
  logic [24:0]           byte_addr;
  logic                  unused_addr;

  assign unused_addr = ^dwnld_addr[26:25];

  // The head word leaves the FIFO when it is latched in LOAD, so a full FIFO
  // still accepts a word in that cycle.
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign push = dwnld_wr && (!full || pop);

  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr_q] <= {dwnld_addr[24:0] & ~AMASK, dwnld_data, dwnld_index};
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      dl_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      dl_q  <= ioctl_download;
      if (dwnld_wr && !push)           ovf_q <= 1'b1;
      else if (ioctl_download && !dl_q) ovf_q <= 1'b0;
    end
  end

  assign byte_w    = 8'(wdata_q >> {lane_q, 3'b000});
  assign byte_addr = waddr_q | 25'(lane_q);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      gcnt_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      widx_q     <= '0;
      core_mod_q <= 7'b0000001;
      dipsw_q    <= '1;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      gcnt_q     <= gcnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      widx_q     <= widx_d;
      core_mod_q <= core_mod_d;
      dipsw_q    <= dipsw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    gcnt_d     = gcnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    widx_d     = widx_q;
    core_mod_d = core_mod_q;
    dipsw_d    = dipsw_q;
    pop        = 1'b0;
    rom_wr     = 1'b0;
    lane_done  = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) state_d = LOAD;
      LOAD: begin
        pop = 1'b1;
        {waddr_d, wdata_d, widx_d} = mem[rptr_q];
        lane_d  = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (widx_q == ROM_IDX) begin
          if (rom_ok) begin
            rom_wr = 1'b1;
            if (GAP > 0) begin
              gcnt_d  = '0;
              state_d = WAIT;
            end else begin
              lane_done = 1'b1;
            end
          end
        end else begin
          if (widx_q == MOD_IDX && lane_q == '0) core_mod_d = byte_w[6:0];
          if (widx_q == DIP_IDX) begin
            for (int i = 0; i < DIPBYTES; i++)
              if (byte_addr == 25'(i)) dipsw_d[8*i +: 8] = byte_w;
          end
          lane_done = 1'b1;
        end
      end
      WAIT: begin
        if (gcnt_q == GLAST) lane_done = 1'b1;
        else gcnt_d = gcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (lane_done) begin
      if (lane_q == LAST) begin
        state_d = (cnt_q != '0) ? LOAD : IDLE;
      end else begin
        lane_d  = lane_q + 1'b1;
        state_d = EMIT;
      end
    end
  end

  assign rom_addr = byte_addr;
  assign rom_data = byte_w;
  assign dipsw    = dipsw_q;
  assign core_mod = core_mod_q;
  assign busy     = (cnt_q != '0) || (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
